// File: rtl/fibo_led_seq.sv
// fibo_led_seq: prescaled WIDTH-bit LED sequencer stepping Fibonacci, Lucas, binary count or a user-seeded recurrence.
// Optional macro FIBO_LED_BOUNCE_EN: overflow reverses the sequence instead of reloading the seeds.
module fibo_led_seq #(
    parameter int               WIDTH      = 8,
    parameter int               CNT_W      = 20,
    parameter logic [CNT_W-1:0] DECIMATION = 20'd20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             restart,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             wrap
);

    localparam logic [1:0]       MODE_FIB  = 2'b00;
    localparam logic [1:0]       MODE_LUC  = 2'b01;
    localparam logic [1:0]       MODE_CNT  = 2'b10;
    localparam logic [1:0]       MODE_USR  = 2'b11;
    localparam logic [CNT_W-1:0] PCNT_LAST = DECIMATION - CNT_W'(1);

    function automatic logic [WIDTH-1:0] first_seed(input logic [1:0] m, input logic [WIDTH-1:0] ua);
        case (m)
            MODE_LUC: first_seed = WIDTH'(2);
            MODE_USR: first_seed = ua;
            default:  first_seed = '0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] second_seed(input logic [1:0] m, input logic [WIDTH-1:0] ub);
        case (m)
            MODE_FIB, MODE_LUC: second_seed = WIDTH'(1);
            MODE_USR:           second_seed = ub;
            default:            second_seed = '0;
        endcase
    endfunction

    logic [WIDTH-1:0] cur, nxt, sa, sb;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] pcnt;
    logic [WIDTH:0]   sum;
    logic             counter_mode, ovf, reload, step;
    logic [WIDTH-1:0] fwd_cur, fwd_nxt;

    assign counter_mode = (mode_q == MODE_CNT);
    assign sum          = {1'b0, cur} + {1'b0, nxt};
    // The counter overflows at all-ones; the recurrences overflow on carry out of the sum.
    assign ovf          = counter_mode ? (&cur) : sum[WIDTH];
    assign fwd_cur      = counter_mode ? cur + WIDTH'(1) : nxt;
    assign fwd_nxt      = counter_mode ? '0 : sum[WIDTH-1:0];
    assign reload       = !reset || restart || (mode != mode_q);
    assign step         = en && (pcnt == PCNT_LAST);
    assign out          = cur;

`ifdef FIBO_LED_BOUNCE_EN
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
    dir_t dir;
    logic at_seeds;

    // Walking backwards ends exactly on the seed pair, since the down step inverts the up step.
    assign at_seeds = (cur == sa) && (nxt == sb);
`endif

    always_ff @(posedge clk) begin
        if (reload) begin
            pcnt   <= '0;
            mode_q <= mode;
            sa     <= first_seed(mode, seed_a);
            sb     <= second_seed(mode, seed_b);
            cur    <= first_seed(mode, seed_a);
            nxt    <= second_seed(mode, seed_b);
            tick   <= 1'b0;
            wrap   <= 1'b0;
`ifdef FIBO_LED_BOUNCE_EN
            dir    <= DIR_UP;
`endif
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (en) begin
                pcnt <= step ? '0 : pcnt + CNT_W'(1);
            end
            if (step) begin
                tick <= 1'b1;
`ifdef FIBO_LED_BOUNCE_EN
                if (dir == DIR_UP) begin
                    if (ovf) begin
                        dir  <= DIR_DOWN;
                        wrap <= 1'b1;
                    end else begin
                        cur <= fwd_cur;
                        nxt <= fwd_nxt;
                    end
                end else if (at_seeds) begin
                    dir  <= DIR_UP;
                    wrap <= 1'b1;
                    if (!ovf) begin
                        cur <= fwd_cur;
                        nxt <= fwd_nxt;
                    end
                end else begin
                    cur <= counter_mode ? cur - WIDTH'(1) : nxt - cur;
                    nxt <= counter_mode ? '0 : cur;
                end
`else
                if (ovf) begin
                    cur  <= sa;
                    nxt  <= sb;
                    wrap <= 1'b1;
                end else begin
                    cur <= fwd_cur;
                    nxt <= fwd_nxt;
                end
`endif
            end
        end
    end

endmodule
